// File: rtl/irq_ctrl_pkg.sv
// Shared constants and priority helpers for the three-source vectored interrupt controller.
package irq_ctrl_pkg;

    localparam int unsigned N_SRC       = 3;
    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned STACK_DEPTH = 3;

    localparam logic [ADDR_W-1:0] VEC0_DEF = 32'h0000_1000;
    localparam logic [ADDR_W-1:0] VEC1_DEF = 32'h0000_1100;
    localparam logic [ADDR_W-1:0] VEC2_DEF = 32'h0000_1200;

    // One-hot of the highest set bit, zero when nothing is set.
    function automatic logic [N_SRC-1:0] highest_onehot(input logic [N_SRC-1:0] v);
        logic [N_SRC-1:0] h;
        h = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (v[i]) h = N_SRC'(1) << i;
        end
        return h;
    endfunction

    // Sources strictly above the current in-service level; all sources when idle.
    function automatic logic [N_SRC-1:0] above_level(input logic [N_SRC-1:0] isr);
        logic [N_SRC-1:0] m;
        m = '1;
        for (int i = 0; i < N_SRC; i++) begin
            if (isr[i]) begin
                for (int j = 0; j <= i; j++) m[j] = 1'b0;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// Request, control and PC-redirect signals between the interrupt controller and its surroundings.
interface irq_ctrl_if;
    import irq_ctrl_pkg::*;

    logic [N_SRC-1:0]  in_irq;
    logic              in_eret;
    logic [ADDR_W-1:0] in_retaddr;
    logic              in_mask_we;
    logic [N_SRC-1:0]  in_mask_din;
    logic              in_ie_set;
    logic              in_ie_clr;
    logic              out_force;
    logic [ADDR_W-1:0] out_faddr;
    logic [N_SRC-1:0]  out_pending;
    logic [N_SRC-1:0]  out_isr;
    logic              out_ie;

    modport master (
        output in_irq, in_eret, in_retaddr, in_mask_we, in_mask_din, in_ie_set, in_ie_clr,
        input  out_force, out_faddr, out_pending, out_isr, out_ie
    );

    modport slave (
        input  in_irq, in_eret, in_retaddr, in_mask_we, in_mask_din, in_ie_set, in_ie_clr,
        output out_force, out_faddr, out_pending, out_isr, out_ie
    );

endinterface

// File: rtl/irq_ctrl_epc_stack.sv
// Resume-address LIFO; entry 0 is the top, push shifts down, pop shifts up.
module epc_stack
    import irq_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [ADDR_W-1:0] i_din,
    output logic [ADDR_W-1:0] o_top
);

    logic [ADDR_W-1:0] r_mem [STACK_DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STACK_DEPTH; i++) r_mem[i] <= '0;
        end else if (i_push) begin
            r_mem[0] <= i_din;
            for (int i = 1; i < STACK_DEPTH; i++) r_mem[i] <= r_mem[i-1];
        end else if (i_pop) begin
            for (int i = 0; i < STACK_DEPTH - 1; i++) r_mem[i] <= r_mem[i+1];
            r_mem[STACK_DEPTH-1] <= '0;
        end
    end

    assign o_top = r_mem[0];

endmodule

// File: rtl/irq_ctrl.sv
// Three-source vectored interrupt controller with fixed priority, nesting and a resume-address stack.
// Drives the PC forced-load port combinationally from registered state and current inputs.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter logic [ADDR_W-1:0] VEC0 = VEC0_DEF,
    parameter logic [ADDR_W-1:0] VEC1 = VEC1_DEF,
    parameter logic [ADDR_W-1:0] VEC2 = VEC2_DEF
) (
    input  logic       in_CLOCK,
    input  logic       in_RST,
    irq_ctrl_if.slave  bus
);

    logic [N_SRC-1:0]  r_irq_prev;
    logic [N_SRC-1:0]  r_pending;
    logic [N_SRC-1:0]  r_isr;
    logic [N_SRC-1:0]  r_mask;
    logic              r_ie;

    logic [N_SRC-1:0]  w_rise;
    logic [N_SRC-1:0]  w_qual;
    logic [N_SRC-1:0]  w_cand_oh;
    logic              w_cand_vld;
    logic              w_eret_take;
    logic              w_take;
    logic [ADDR_W-1:0] w_vec;
    logic [ADDR_W-1:0] w_top;

    assign w_rise      = bus.in_irq & ~r_irq_prev;
    assign w_qual      = r_pending & r_mask & {N_SRC{r_ie}} & above_level(r_isr);
    assign w_cand_oh   = highest_onehot(w_qual);
    assign w_cand_vld  = |w_qual;
    assign w_eret_take = bus.in_eret & (|r_isr);
    // ERET wins; a candidate in the same cycle waits for the next one.
    assign w_take      = w_cand_vld & ~w_eret_take;

    always_comb begin
        w_vec = VEC0;
        if (w_cand_oh[2])      w_vec = VEC2;
        else if (w_cand_oh[1]) w_vec = VEC1;
    end

    always_comb begin
        bus.out_force = 1'b0;
        bus.out_faddr = '0;
        if (!in_RST) begin
            if (w_eret_take) begin
                bus.out_force = 1'b1;
                bus.out_faddr = w_top;
            end else if (w_cand_vld) begin
                bus.out_force = 1'b1;
                bus.out_faddr = w_vec;
            end
        end
    end

    always_ff @(posedge in_CLOCK or posedge in_RST) begin
        if (in_RST) begin
            r_irq_prev <= '0;
            r_pending  <= '0;
            r_isr      <= '0;
            r_mask     <= '1;
            r_ie       <= 1'b0;
        end else begin
            r_irq_prev <= bus.in_irq;
            // A fresh edge in the clearing cycle keeps the request pending.
            r_pending  <= (r_pending & ~(w_take ? w_cand_oh : N_SRC'(0))) | w_rise;
            if (w_eret_take)
                r_isr <= r_isr & ~highest_onehot(r_isr);
            else if (w_take)
                r_isr <= r_isr | w_cand_oh;
            if (bus.in_mask_we)
                r_mask <= bus.in_mask_din;
            if (bus.in_ie_clr)
                r_ie <= 1'b0;
            else if (bus.in_ie_set)
                r_ie <= 1'b1;
        end
    end

    epc_stack u_stack (
        .clk    (in_CLOCK),
        .rst    (in_RST),
        .i_push (w_take),
        .i_pop  (w_eret_take),
        .i_din  (bus.in_retaddr),
        .o_top  (w_top)
    );

    assign bus.out_pending = r_pending;
    assign bus.out_isr     = r_isr;
    assign bus.out_ie      = r_ie;

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: a behavioural model predicts every cycle's outputs into a queue,
// and a negedge monitor pops and compares them against the DUT.
module tb_irq_ctrl;
    import irq_ctrl_pkg::*;

    typedef struct {
        bit          force_;
        logic [31:0] faddr;
        bit   [2:0]  pend;
        bit   [2:0]  isr;
        bit          ie;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    irq_ctrl_if bus ();

    irq_ctrl dut (
        .in_CLOCK (clk),
        .in_RST   (rst),
        .bus      (bus)
    );

    int checks = 0;
    int errors = 0;
    int ncyc   = 0;
    exp_t exp_q[$];

    // Model state
    bit [2:0]    m_pend, m_isr, m_mask, m_prev;
    bit          m_ie;
    logic [31:0] m_stack[$];

    // Inputs currently applied (seen by the next rising edge)
    bit          d_rst = 1'b1;
    bit [2:0]    d_irq = '0;
    bit          d_eret = 1'b0;
    logic [31:0] d_ra = '0;
    bit          d_mwe = 1'b0;
    bit [2:0]    d_md = '0;
    bit          d_ies = 1'b0;
    bit          d_iec = 1'b0;

    function automatic logic [31:0] vec_of(input int i);
        case (i)
            0:       return 32'h0000_1000;
            1:       return 32'h0000_1100;
            default: return 32'h0000_1200;
        endcase
    endfunction

    function automatic int level_of(input bit [2:0] isr);
        int lvl = -1;
        for (int i = 0; i < 3; i++) if (isr[i]) lvl = i;
        return lvl;
    endfunction

    function automatic int m_cand();
        int c = -1;
        int lvl = level_of(m_isr);
        for (int i = 0; i < 3; i++)
            if (m_pend[i] && m_mask[i] && m_ie && i > lvl) c = i;
        return c;
    endfunction

    task automatic m_reset();
        m_pend = '0; m_isr = '0; m_mask = 3'b111; m_ie = 1'b0; m_prev = '0;
        m_stack.delete();
    endtask

    // State update at a rising edge, using the inputs applied during the preceding cycle.
    task automatic m_edge();
        bit [2:0] rise;
        int c;
        if (d_rst) begin
            m_reset();
            return;
        end
        rise = d_irq & ~m_prev;
        m_prev = d_irq;
        c = m_cand();
        if (d_eret && m_isr != 0) begin
            void'(m_stack.pop_front());
            m_isr[level_of(m_isr)] = 1'b0;
        end else if (c >= 0) begin
            m_stack.push_front(d_ra);
            m_pend[c] = 1'b0;
            m_isr[c] = 1'b1;
        end
        m_pend = m_pend | rise;
        if (d_mwe) m_mask = d_md;
        if (d_iec) m_ie = 1'b0;
        else if (d_ies) m_ie = 1'b1;
    endtask

    task automatic push_exp();
        exp_t e;
        int c;
        if (d_rst) m_reset();
        e.force_ = 1'b0; e.faddr = '0;
        c = m_cand();
        if (!d_rst) begin
            if (d_eret && m_isr != 0) begin
                e.force_ = 1'b1; e.faddr = m_stack[0];
            end else if (c >= 0) begin
                e.force_ = 1'b1; e.faddr = vec_of(c);
            end
        end
        e.pend = m_pend; e.isr = m_isr; e.ie = m_ie;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input bit r, input bit [2:0] irq, input bit eret, input logic [31:0] ra,
                       input bit mwe, input bit [2:0] md, input bit ies, input bit iec);
        @(posedge clk);
        m_edge();
        #1;
        d_rst = r; d_irq = irq; d_eret = eret; d_ra = ra;
        d_mwe = mwe; d_md = md; d_ies = ies; d_iec = iec;
        rst = r;
        bus.in_irq = irq; bus.in_eret = eret; bus.in_retaddr = ra;
        bus.in_mask_we = mwe; bus.in_mask_din = md;
        bus.in_ie_set = ies; bus.in_ie_clr = iec;
        push_exp();
    endtask

    task automatic idle(input logic [31:0] ra, input int n);
        for (int i = 0; i < n; i++) cyc(0, 3'b000, 0, ra, 0, 3'b000, 0, 0);
    endtask

    task automatic eret(input logic [31:0] ra);
        cyc(0, 3'b000, 1, ra, 0, 3'b000, 0, 0);
    endtask

    task automatic pulse(input bit [2:0] irq, input logic [31:0] ra);
        cyc(0, irq, 0, ra, 0, 3'b000, 0, 0);
    endtask

    always @(negedge clk) begin
        ncyc++;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (bus.out_force !== e.force_ || bus.out_faddr !== e.faddr ||
                bus.out_pending !== e.pend || bus.out_isr !== e.isr || bus.out_ie !== e.ie) begin
                errors++;
                $display("FAIL outputs cyc=%0d act force=%b faddr=%h pend=%b isr=%b ie=%b exp force=%b faddr=%h pend=%b isr=%b ie=%b",
                         ncyc, bus.out_force, bus.out_faddr, bus.out_pending, bus.out_isr, bus.out_ie,
                         e.force_, e.faddr, e.pend, e.isr, e.ie);
            end
        end
    end

    initial begin
        bus.in_irq = '0; bus.in_eret = 1'b0; bus.in_retaddr = '0;
        bus.in_mask_we = 1'b0; bus.in_mask_din = '0;
        bus.in_ie_set = 1'b0; bus.in_ie_clr = 1'b0;
        m_reset();

        // Reset, then enable
        cyc(1, 0, 0, 32'h0, 0, 0, 0, 0);
        cyc(1, 0, 0, 32'h0, 0, 0, 0, 0);
        cyc(0, 0, 0, 32'h40, 0, 0, 1, 0);

        // Basic entry, nesting and returns
        pulse(3'b001, 32'h40);
        idle(32'h40, 1);
        idle(32'h1008, 1);
        pulse(3'b100, 32'h1008);
        idle(32'h1008, 1);
        idle(32'h1204, 2);
        eret(32'h1204);
        eret(32'h1010);
        eret(32'h44);
        idle(32'h44, 1);

        // Blocking by a higher level, then release on ERET
        pulse(3'b100, 32'h80);
        idle(32'h80, 2);
        pulse(3'b010, 32'h1204);
        idle(32'h1208, 2);
        eret(32'h1208);
        idle(32'h84, 2);
        eret(32'h1104);
        idle(32'h84, 1);

        // Simultaneous edges: source 1 first, then source 0 nests? (0 is lower, waits)
        pulse(3'b011, 32'h90);
        idle(32'h90, 2);
        eret(32'h1100);
        idle(32'h94, 2);
        eret(32'h1004);
        idle(32'h98, 1);

        // Mask and global enable
        cyc(0, 3'b000, 0, 32'ha0, 1, 3'b110, 0, 0);
        pulse(3'b001, 32'ha0);
        idle(32'ha0, 2);
        cyc(0, 3'b000, 0, 32'ha0, 1, 3'b111, 0, 0);
        idle(32'ha0, 2);
        eret(32'h1000);
        cyc(0, 3'b000, 0, 32'ha4, 0, 3'b000, 0, 1);
        pulse(3'b001, 32'ha4);
        idle(32'ha4, 3);
        cyc(0, 3'b000, 0, 32'ha4, 0, 3'b000, 1, 1);
        idle(32'ha4, 2);
        cyc(0, 3'b000, 0, 32'ha4, 0, 3'b000, 1, 0);
        idle(32'ha4, 2);

        // ERET with nothing in service
        eret(32'h1000);
        eret(32'h1000);
        eret(32'h1000);

        // Reset mid-handler with a line held high across release
        pulse(3'b010, 32'hc0);
        idle(32'hc0, 2);
        cyc(1, 3'b001, 0, 32'hc0, 0, 0, 0, 0);
        cyc(1, 3'b001, 0, 32'hc0, 0, 0, 0, 0);
        cyc(0, 3'b001, 0, 32'hc0, 0, 0, 1, 0);
        cyc(0, 3'b001, 0, 32'hc0, 0, 0, 0, 0);
        cyc(0, 3'b001, 0, 32'hc4, 0, 0, 0, 0);
        eret(32'h1000);
        cyc(0, 3'b001, 0, 32'hc8, 0, 0, 0, 0);
        idle(32'hc8, 2);

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            bit          r;
            bit [2:0]    irq;
            r   = ($urandom_range(0, 249) == 0);
            irq = d_irq;
            for (int b = 0; b < 3; b++)
                if ($urandom_range(0, 5) == 0) irq[b] = ~irq[b];
            cyc(r, irq, ($urandom_range(0, 4) == 0), $urandom,
                ($urandom_range(0, 19) == 0), 3'($urandom),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 29) == 0));
        end

        idle(32'h0, 2);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain act=%0d exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Three-source vectored interrupt controller feeding the PC unit's forced-load port (`in_force`/`in_faddr`). It latches interrupt requests on their rising edges and resolves them by fixed priority with nesting. On entry it redirects the PC to the handler vector and saves the resume address on a 3-entry stack; on ERET it redirects the PC back to that address. It sits directly upstream of the PC register and is driven by the board's interrupt buttons and the control unit's ERET decode.

## Interface
- VEC0, default 32'h0000_1000: handler address for source 0 (lowest priority)
- VEC1, default 32'h0000_1100: handler address for source 1
- VEC2, default 32'h0000_1200: handler address for source 2 (highest priority)
- in_CLOCK  in  1  system clock; all state changes on the rising edge
- in_RST  in  1  asynchronous, active-high reset
- in_irq  in  3  raw interrupt request lines, level inputs; bit i is source i
- in_eret  in  1  ERET instruction decoded this cycle
- in_retaddr  in  32  address the PC would load this cycle without a force (resume point)
- in_mask_we  in  1  write enable for the per-source enable mask
- in_mask_din  in  3  new mask value; 1 = source enabled
- in_ie_set / in_ie_clr  in  1 / 1  set / clear the global interrupt enable
- out_force  out  1  force the PC to out_faddr at the next edge
- out_faddr  out  32  forced PC target
- out_pending  out  3  pending latches, for display
- out_isr  out  3  in-service bits, for display
- out_ie  out  1  global enable

## Operation
- Edge detect: each `irq_prev[i]` registers `in_irq[i]`. `pending[i]` sets when `in_irq[i] & ~irq_prev[i]`. `irq_prev` resets to 0, so a line already high after reset counts as one edge.
- Current level L is the highest set bit of `isr`; L = none when `isr == 0`.
- Candidate: the highest i with `pending[i] & mask[i] & ie` and i > L (any i qualifies when L = none).
- Output select, all combinational from registered state and inputs:
  - If `in_eret` and `isr != 0`: `out_force = 1`, `out_faddr` = stack top.
  - Else if a candidate exists: `out_force = 1`, `out_faddr` = VECi.
  - Else: `out_force = 0`, `out_faddr = 0`.
- Entry, at the edge where a candidate is taken:
  - push `in_retaddr`
  - clear `pending[i]`
  - set `isr[i]`
- Return, at the edge where ERET is taken:
  - pop the stack
  - clear the highest set `isr` bit
- ERET with `isr == 0` is ignored: no force, no state change.
- Simultaneous events:
  - ERET has precedence over entry; a candidate waits at least one cycle.
  - A new rising edge on source i in the same cycle that `pending[i]` is cleared by entry leaves `pending[i] = 1` (set wins).
- Stack: depth 3. Each push needs a strictly higher level, so overflow and underflow cannot occur. Entries beyond the depth are not reachable.
- Mask / IE:
  - `in_mask_we` loads `mask` at the edge.
  - `in_ie_clr` has precedence over `in_ie_set`.
  - The mask and IE gate only acceptance; pending latches are kept while masked.
- Reset: `pending = 0`, `isr = 0`, stack entries = 0, `mask = 3'b111`, `ie = 0`, `irq_prev = 0`. All outputs are 0 during reset.

## Timing
- Request latency: an edge on `in_irq` sampled at edge k sets `pending` at edge k. `out_force` asserts in cycle k+1, and the PC holds VECi after edge k+1.
- A masked or disabled pending request is taken in the first cycle after the mask or IE enables it.
- ERET: `out_force` is asserted in the same cycle as `in_eret`, and the PC holds the resume address after that edge.
- `out_force` is a single-cycle pulse per accepted event, unless a further qualifying event exists in the next cycle.
- Reset mid-handler: all state clears immediately; no return is possible afterwards.

## Structure
- A shared header defines the source count (3), address width (32) and the default vector constants.
- Sub-module `epc_stack`: a 3-entry × 32-bit LIFO with push, pop and a top output, plus asynchronous reset. Push and pop are never asserted together.
- Priority select and level compare stay in `irq_ctrl`.

## Test plan
- Basic entry:
  - Stimulus: reset, `ie` set; pulse `in_irq[0]`; `in_retaddr = 32'h0000_0040`.
  - Response: `out_force = 1` with `out_faddr = 32'h1000` one cycle after the pending latch; `isr = 3'b001`.
- Return:
  - Stimulus: while in the handler above, assert `in_eret`.
  - Response: same cycle, `out_force = 1` and `out_faddr = 32'h40`; `isr = 0` after the edge.
- Nesting:
  - Stimulus: during the source-0 handler (`in_retaddr = 32'h1008`), pulse `in_irq[2]`.
  - Response: force to `32'h1200`. The first ERET returns to `32'h1008`, the second to `32'h40`.
- Blocking:
  - Stimulus 1: during the source-2 handler, pulse `in_irq[1]`. Response: `pending = 3'b010`, no force. After ERET, `out_force = 1` to `32'h1100`.
  - Stimulus 2: simultaneous edges on `in_irq[0]` and `in_irq[1]`. Response: source 1 is taken first.
- Mask / IE:
  - Stimulus: `mask = 3'b110`, pulse `in_irq[0]`.
  - Response: pending but no force. Writing `mask = 3'b111` forces to `32'h1000` next cycle. With `ie = 0`, no force at all.
- Corner cases:
  - ERET with `isr = 0`: no force.
  - `in_RST` asserted mid-handler: all outputs are 0 immediately.
  - `in_irq` held high across reset release: exactly one pending event.
